cacheline_arbiter: RTL and testbench

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

---
 rtl/cache_types.sv | 20 ++
 rtl/rr_arbiter2.sv | 19 +
 rtl/cacheline_arbiter.sv | 113 +++++++++++
 tb/tb_cacheline_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_types.sv
// Shared types for the cache-line arbiter: FSM states, owner encoding and the
// registered copy of a granted line request.
package cache_types;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic ARB_OWNER_I = 1'b0;
  localparam logic ARB_OWNER_D = 1'b1;

  typedef struct packed {
    logic [31:0]  addr;
    logic         write;
    logic [255:0] wdata;
  } line_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: req[0]=icache, req[1]=dcache; last is the owner
// granted most recently, which loses a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// Arbitrates icache and dcache line requests onto the single downstream line
// buffer port, one transaction at a time, round-robin on ties.
//
// state    | meaning
// ARB_IDLE | no transaction; a pending request is granted and registered
// ARB_BUSY | registered request driven downstream until l2cache_resp
// ARB_RESP | one dead cycle so a stale (still held) request is not re-granted
module cacheline_arbiter
  import cache_types::*;
#(
  parameter logic FAIR_INIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic [31:0]  icache_addr,
  input  logic         icache_read,
  input  logic         icache_write,
  input  logic [255:0] icache_wdata,
  output logic [255:0] icache_rdata,
  output logic         icache_resp,

  input  logic [31:0]  dcache_addr,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [255:0] dcache_wdata,
  output logic [255:0] dcache_rdata,
  output logic         dcache_resp,

  output logic [31:0]  l2cache_addr,
  output logic         l2cache_read,
  output logic         l2cache_write,
  output logic [255:0] l2cache_wdata,
  input  logic [255:0] l2cache_rdata,
  input  logic         l2cache_resp
);

  arb_state_t state_q, state_d;
  logic       owner_q;
  logic       last_q;
  line_req_t  req_q;
  line_req_t  win_req;
  logic [255:0] line_q;
  logic [1:0] req_vec;
  logic [1:0] gnt;
  logic       grant;
  logic       busy;
  logic       done;

  assign req_vec = {dcache_read | dcache_write, icache_read | icache_write};

  rr_arbiter2 u_rr (
    .req  (req_vec),
    .last (last_q),
    .gnt  (gnt)
  );

  // Write wins when a requester raises read and write together.
  always_comb begin
    if (gnt[1]) begin
      win_req.addr  = dcache_addr;
      win_req.write = dcache_write;
      win_req.wdata = dcache_wdata;
    end else begin
      win_req.addr  = icache_addr;
      win_req.write = icache_write;
      win_req.wdata = icache_wdata;
    end
  end

  assign grant = (state_q == ARB_IDLE) && (|req_vec);
  assign busy  = (state_q == ARB_BUSY);
  assign done  = busy && l2cache_resp;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (|req_vec) state_d = ARB_BUSY;
      ARB_BUSY: if (l2cache_resp) state_d = ARB_RESP;
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWNER_I;
      last_q  <= ~FAIR_INIT;
      req_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= gnt[1];
        last_q  <= gnt[1];
        req_q   <= win_req;
      end
      if (done) line_q <= l2cache_rdata;
    end
  end

  assign l2cache_addr  = req_q.addr;
  assign l2cache_wdata = req_q.wdata;
  assign l2cache_read  = busy && !l2cache_resp && !req_q.write;
  assign l2cache_write = busy && !l2cache_resp &&  req_q.write;

  assign icache_resp  = done && (owner_q == ARB_OWNER_I);
  assign dcache_resp  = done && (owner_q == ARB_OWNER_D);
  assign icache_rdata = icache_resp ? l2cache_rdata : line_q;
  assign dcache_rdata = dcache_resp ? l2cache_rdata : line_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: inputs driven on the falling edge,
// outputs checked 2 time units later, line buffer modelled by hand.
module tb_cacheline_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  icache_addr, dcache_addr, l2cache_addr;
  logic         icache_read, icache_write, dcache_read, dcache_write;
  logic [255:0] icache_wdata, dcache_wdata, l2cache_wdata;
  logic [255:0] icache_rdata, dcache_rdata, l2cache_rdata;
  logic         icache_resp, dcache_resp, l2cache_resp;
  logic         l2cache_read, l2cache_write;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] line_a, line_b, line_c, line_d, wd_d;

  always #5 clk = ~clk;

  cacheline_arbiter #(.FAIR_INIT(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache_addr   (icache_addr),
    .icache_read   (icache_read),
    .icache_write  (icache_write),
    .icache_wdata  (icache_wdata),
    .icache_rdata  (icache_rdata),
    .icache_resp   (icache_resp),
    .dcache_addr   (dcache_addr),
    .dcache_read   (dcache_read),
    .dcache_write  (dcache_write),
    .dcache_wdata  (dcache_wdata),
    .dcache_rdata  (dcache_rdata),
    .dcache_resp   (dcache_resp),
    .l2cache_addr  (l2cache_addr),
    .l2cache_read  (l2cache_read),
    .l2cache_write (l2cache_write),
    .l2cache_wdata (l2cache_wdata),
    .l2cache_rdata (l2cache_rdata),
    .l2cache_resp  (l2cache_resp)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Returns in the first busy cycle (checked 2 units after the falling edge).
  task automatic wait_req(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      settle();
      seen = l2cache_read | l2cache_write;
    end
    chk(tag, {255'd0, seen}, 256'd1);
  endtask

  // Called in busy cycle 1; raises l2cache_resp in busy cycle 'beats'.
  task automatic respond(input int beats, input logic [255:0] line);
    for (int i = 1; i < beats; i++) cyc();
    l2cache_rdata = line;
    l2cache_resp  = 1'b1;
    settle();
  endtask

  initial begin
    line_a = {8{32'hA5A5_0001}};
    line_b = {8{32'hB00B_0002}};
    line_c = {8{32'hC0DE_0003}};
    line_d = {8{32'hD00D_0004}};
    wd_d   = {8{32'h1234_5678}};
    rst_n = 1'b0;
    icache_addr = '0; icache_read = 0; icache_write = 0; icache_wdata = '0;
    dcache_addr = '0; dcache_read = 0; dcache_write = 0; dcache_wdata = '0;
    l2cache_rdata = '0; l2cache_resp = 0;

    // Reset state
    cyc(); cyc(); settle();
    chk("rst_l2_read",  l2cache_read,  0);
    chk("rst_l2_write", l2cache_write, 0);
    chk("rst_i_resp",   icache_resp,   0);
    chk("rst_d_resp",   dcache_resp,   0);
    cyc();
    rst_n = 1'b1;

    // Single icache read, resp in the 4th busy cycle
    cyc();
    icache_addr = 32'h0000_1000; icache_read = 1;
    settle();
    chk("t1_idle_no_req", l2cache_read, 0);
    cyc(); settle();
    chk("t1_read_c1", l2cache_read, 1);
    chk("t1_addr",    l2cache_addr, 32'h0000_1000);
    chk("t1_write_c1", l2cache_write, 0);
    cyc(); cyc(); settle();
    chk("t1_read_c3", l2cache_read, 1);
    cyc();
    l2cache_rdata = line_a; l2cache_resp = 1;
    settle();
    chk("t1_i_resp",  icache_resp,  1);
    chk("t1_i_rdata", icache_rdata, line_a);
    chk("t1_d_resp",  dcache_resp,  0);
    chk("t1_read_dropped", l2cache_read, 0);
    cyc();
    l2cache_resp = 0; icache_read = 0;
    settle();
    chk("t1_i_resp_1cyc", icache_resp, 0);
    chk("t1_rdata_held",  icache_rdata, line_a);
    // Request dropped after resp: nothing more goes downstream
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      chk("t6_no_second_req", {l2cache_read, l2cache_write}, 0);
    end

    // Tie after reset: dcache write wins, icache follows
    do_reset();
    cyc();
    icache_addr = 32'h0000_0100; icache_read = 1;
    dcache_addr = 32'h0000_0200; dcache_write = 1; dcache_wdata = wd_d;
    settle();
    chk("t2_idle_no_req", {l2cache_read, l2cache_write}, 0);
    cyc(); settle();
    chk("t2_d_write", {l2cache_read, l2cache_write}, 2'b01);
    chk("t2_d_addr",  l2cache_addr,  32'h0000_0200);
    chk("t2_d_wdata", l2cache_wdata, wd_d);
    respond(2, line_b);
    chk("t2_d_resp",  dcache_resp,  1);
    chk("t2_d_rdata", dcache_rdata, line_b);
    chk("t2_i_resp0", icache_resp,  0);
    cyc();
    l2cache_resp = 0; dcache_write = 0;
    settle();
    chk("t2_resp_gap", {l2cache_read, l2cache_write}, 0);
    cyc(); settle();
    chk("t2_idle_gap", {l2cache_read, l2cache_write}, 0);
    cyc(); settle();
    chk("t2_i_read", l2cache_read, 1);
    chk("t2_i_addr", l2cache_addr, 32'h0000_0100);
    respond(1, line_c);
    chk("t2_i_resp",  icache_resp,  1);
    chk("t2_i_rdata", icache_rdata, line_c);
    chk("t2_d_rdata_held", dcache_rdata, line_b);
    cyc();
    l2cache_resp = 0; icache_read = 0;

    // Both hold requests: D, I, D, I
    do_reset();
    cyc();
    icache_addr = 32'h0000_0300; icache_read = 1;
    dcache_addr = 32'h0000_0400; dcache_read = 1;
    for (int t = 0; t < 4; t++) begin
      wait_req("t3_req_seen");
      chk("t3_addr", l2cache_addr, (t % 2 == 0) ? 32'h0000_0400 : 32'h0000_0300);
      respond(1, line_d ^ 256'(t));
      chk("t3_owner", {dcache_resp, icache_resp}, (t % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
      l2cache_resp = 0;
    end
    icache_read = 0; dcache_read = 0;

    // read=write=1 goes out as a write; owner changes during busy ignored
    cyc();
    dcache_addr = 32'h0000_0500; dcache_read = 1; dcache_write = 1;
    wait_req("t4_req_seen");
    chk("t4_op", {l2cache_read, l2cache_write}, 2'b01);
    dcache_addr = 32'h0000_0ABC; dcache_write = 0;
    cyc(); settle();
    chk("t4_addr_kept", l2cache_addr, 32'h0000_0500);
    chk("t4_op_kept", {l2cache_read, l2cache_write}, 2'b01);
    respond(1, line_a);
    chk("t4_d_resp", dcache_resp, 1);
    cyc();
    l2cache_resp = 0; dcache_read = 0;

    // Reset two cycles into busy
    cyc();
    icache_addr = 32'h0000_0600; icache_read = 1;
    wait_req("t5_req_seen");
    cyc();
    rst_n = 0;
    settle();
    chk("t5_read_drop", l2cache_read, 0);
    icache_read = 0;
    cyc();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); settle();
      chk("t5_no_resp", {l2cache_read, l2cache_write, icache_resp, dcache_resp}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
